// File: rtl/cpu_run_monitor_pkg.sv
// Shared run-state encodings and helpers for the CPU run monitor.
package cpu_run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALTED  = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  function automatic logic is_done(input state_e s);
    return (s == ST_HALTED) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/cpu_run_monitor_trace_ring.sv
// Circular trace buffer of the most recent retired PCs with a 1-cycle registered readout.
// Instruction words are stored only when TRACE_INSTR_EN is defined.
module cpu_run_monitor_trace_ring #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [PC_W-1:0]          wr_pc_i,
  input  logic [31:0]              wr_instr_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic                     rd_valid_o,
  output logic                     rd_err_o,
  output logic [PC_W-1:0]          rd_pc_o,
  output logic [31:0]              rd_instr_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int FW = IW + 1;

  logic [PC_W-1:0] mem_pc_q [DEPTH];
  logic [IW-1:0]   wr_ptr_q;
  logic [FW-1:0]   fill_q;
  logic [IW-1:0]   rd_addr_s;
  logic            rd_err_s;
  logic            rd_valid_q;
  logic            rd_err_q;
  logic [PC_W-1:0] rd_pc_q;

  // Oldest entry sits fill slots behind the write pointer; a full ring makes that the pointer itself.
  assign rd_addr_s = wr_ptr_q - fill_q[IW-1:0] + rd_idx_i;
  assign rd_err_s  = ({1'b0, rd_idx_i} >= fill_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else if (we_i) begin
      wr_ptr_q <= wr_ptr_q + IW'(1);
      if (fill_q != FW'(DEPTH)) begin
        fill_q <= fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_pc_q[wr_ptr_q] <= wr_pc_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_pc_q    <= '0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_err_q <= rd_err_s;
        rd_pc_q  <= rd_err_s ? '0 : mem_pc_q[rd_addr_s];
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign rd_pc_o    = rd_pc_q;

`ifdef TRACE_INSTR_EN
  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] rd_instr_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_instr_q[wr_ptr_q] <= wr_instr_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_instr_q <= '0;
    end else if (rd_en_i) begin
      rd_instr_q <= rd_err_s ? 32'h0 : mem_instr_q[rd_addr_s];
    end
  end

  assign rd_instr_o = rd_instr_q;
`else
  logic unused_instr_s;
  assign unused_instr_s = ^wr_instr_i;
  assign rd_instr_o     = 32'h0;
`endif

endmodule

// File: rtl/cpu_run_monitor.sv
// Run control, cycle/retire counters, halt and watchdog detection for the single-cycle CPU.
// Optional TRACE_INSTR_EN also records instruction words in the trace ring.
module cpu_run_monitor
  import cpu_run_monitor_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 4096,
  parameter int HALT_REPEAT = 2,
  parameter int CNT_W       = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     retire_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [31:0]              instr_i,
  input  logic [PC_W-1:0]          end_pc_i,
  output logic [1:0]               state_o,
  output logic                     done_o,
  output logic [CNT_W-1:0]         cycle_count_o,
  output logic [CNT_W-1:0]         retire_count_o,
  input  logic                     rd_req_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic                     rd_valid_o,
  output logic                     rd_err_o,
  output logic [PC_W-1:0]          rd_pc_o,
  output logic [31:0]              rd_instr_o
);

  localparam int REP_W = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             last_vld_q, last_vld_d;

  logic             we_s;
  logic             clr_s;
  logic             same_pc_s;
  logic [REP_W-1:0] new_rep_s;
  logic             halt_s;
  logic             timeout_s;

  assign we_s      = (state_q == ST_RUN) && retire_i;
  assign clr_s     = start_i && (state_q != ST_RUN);
  // last_pc is only compared once this run has retired something, so a stale PC cannot fake a loop.
  assign same_pc_s = last_vld_q && (pc_i == last_pc_q);
  assign new_rep_s = same_pc_s ? (rep_q + REP_W'(1)) : '0;
  assign halt_s    = we_s && ((pc_i == end_pc_i) || (new_rep_s == REP_W'(HALT_REPEAT - 1)));
  assign timeout_s = (cyc_q == CNT_W'(MAX_CYCLES - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      ret_q      <= '0;
      rep_q      <= '0;
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
      rep_q      <= rep_d;
      last_pc_q  <= last_pc_d;
      last_vld_q <= last_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    rep_d      = rep_q;
    last_pc_d  = last_pc_q;
    last_vld_d = last_vld_q;
    case (state_q)
      ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
        if (start_i) begin
          state_d    = ST_RUN;
          cyc_d      = '0;
          ret_d      = '0;
          rep_d      = '0;
          last_vld_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (cyc_q != {CNT_W{1'b1}}) begin
          cyc_d = cyc_q + CNT_W'(1);
        end
        if (retire_i) begin
          if (ret_q != {CNT_W{1'b1}}) begin
            ret_d = ret_q + CNT_W'(1);
          end
          rep_d      = new_rep_s;
          last_pc_d  = pc_i;
          last_vld_d = 1'b1;
        end
        // A halting retire takes priority over a watchdog expiry in the same cycle.
        if (halt_s) begin
          state_d = ST_HALTED;
        end else if (timeout_s) begin
          state_d = ST_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  cpu_run_monitor_trace_ring #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH)
  ) u_trace_ring (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (clr_s),
    .we_i       (we_s),
    .wr_pc_i    (pc_i),
    .wr_instr_i (instr_i),
    .rd_en_i    (rd_req_i && is_done(state_q)),
    .rd_idx_i   (rd_idx_i),
    .rd_valid_o (rd_valid_o),
    .rd_err_o   (rd_err_o),
    .rd_pc_o    (rd_pc_o),
    .rd_instr_o (rd_instr_o)
  );

  assign state_o        = state_q;
  assign done_o         = is_done(state_q);
  assign cycle_count_o  = cyc_q;
  assign retire_count_o = ret_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor (watchdog shortened to 64 cycles).
module tb_cpu_run_monitor;

  localparam int PC_W  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int MAXC  = 64;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] instr;
  } rd_exp_t;

  logic             clk, reset, start, retire, rd_req;
  logic [PC_W-1:0]  pc, end_pc;
  logic [31:0]      instr;
  logic [3:0]       rd_idx;
  logic [1:0]       state;
  logic             done, rd_valid, rd_err;
  logic [CNT_W-1:0] cycle_count, retire_count;
  logic [PC_W-1:0]  rd_pc;
  logic [31:0]      rd_instr;

  rd_exp_t exp_q[$];
  rd_exp_t mon_e;
  int checks   = 0;
  int failures = 0;
  int n;

  cpu_run_monitor #(
    .PC_W(PC_W), .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_REPEAT(2), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .retire_i(retire),
    .pc_i(pc), .instr_i(instr), .end_pc_i(end_pc),
    .state_o(state), .done_o(done),
    .cycle_count_o(cycle_count), .retire_count_o(retire_count),
    .rd_req_i(rd_req), .rd_idx_i(rd_idx),
    .rd_valid_o(rd_valid), .rd_err_o(rd_err), .rd_pc_o(rd_pc), .rd_instr_o(rd_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ei(input logic [31:0] w);
`ifdef TRACE_INSTR_EN
    return w;
`else
    return 32'h0;
`endif
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_retire(input logic [31:0] p, input logic [31:0] w);
    retire = 1'b1; pc = p; instr = w;
    tick();
    retire = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd(input int idx, input rd_exp_t e);
    rd_req = 1'b1;
    rd_idx = 4'(idx);
    exp_q.push_back(e);
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: every read response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected actual=rd_valid required=no_response pc=0x%0h", rd_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_err", 64'(rd_err), 64'(mon_e.err));
        chk("rd_pc", 64'(rd_pc), 64'(mon_e.pc));
        chk("rd_instr", 64'(rd_instr), 64'(mon_e.instr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; retire = 1'b0; rd_req = 1'b0;
    pc = '0; instr = '0; end_pc = 32'hFFFF_FFF0; rd_idx = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_state", 64'(state), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_cycles", 64'(cycle_count), 64'h0);
    chk("rst_retires", 64'(retire_count), 64'h0);

    // 1: asynchronous reset mid-run, then a read request must be ignored
    do_start();
    chk("t1_run", 64'(state), 64'h1);
    for (int i = 0; i < 5; i++) do_retire(32'h100 + 32'(4 * i), 32'h0);
    chk("t1_retires", 64'(retire_count), 64'd5);
    #2 reset = 1'b1;
    #1;
    chk("t1_rst_state", 64'(state), 64'h0);
    chk("t1_rst_cycles", 64'(cycle_count), 64'h0);
    chk("t1_rst_retires", 64'(retire_count), 64'h0);
    tick();
    reset = 1'b0;
    rd_req = 1'b1; rd_idx = 4'd0;
    tick();
    rd_req = 1'b0;
    chk("t1_rd_ignored", 64'(rd_valid), 64'h0);

    // 2: end_pc halt after 7 retires, then frozen trace readout
    end_pc = 32'd24;
    do_start();
    for (int i = 0; i < 6; i++) do_retire(32'(4 * i), 32'h1000 + 32'(i));
    chk("t2_still_run", 64'(state), 64'h1);
    do_retire(32'd24, 32'h1006);
    chk("t2_halted", 64'(state), 64'h2);
    chk("t2_done", 64'(done), 64'h1);
    chk("t2_retires", 64'(retire_count), 64'd7);
    do_retire(32'd28, 32'h1007);
    chk("t2_frozen", 64'(retire_count), 64'd7);
    for (int i = 0; i < 7; i++) rd(i, rd_exp_t'{1'b0, 32'(4 * i), ei(32'h1000 + 32'(i))});
    rd(7, rd_exp_t'{1'b1, 32'h0, 32'h0});

    // 3: 18 linear retires, jump to 0x90 and loop there (20 retires total, ring wrapped)
    end_pc = 32'hFFFF_FFF0;
    do_start();
    for (int k = 0; k < 18; k++) do_retire(32'h40 + 32'(4 * k), 32'hA500_0000 + 32'(k));
    do_retire(32'h90, 32'h1000_FFFF);
    chk("t3_still_run", 64'(state), 64'h1);
    do_retire(32'h90, 32'h1000_FFFF);
    chk("t3_halted", 64'(state), 64'h2);
    chk("t3_retires", 64'(retire_count), 64'd20);
    rd(0, rd_exp_t'{1'b0, 32'h50, ei(32'hA500_0004)});
    rd(13, rd_exp_t'{1'b0, 32'h84, ei(32'hA500_0011)});
    rd(14, rd_exp_t'{1'b0, 32'h90, ei(32'h1000_FFFF)});
    rd(15, rd_exp_t'{1'b0, 32'h90, ei(32'h1000_FFFF)});

    // 4: watchdog with no retires
    do_start();
    n = 0;
    while (state == 2'b01 && n < 200) begin tick(); n++; end
    chk("t4_run_cycles", 64'(n), 64'd64);
    chk("t4_timeout", 64'(state), 64'h3);
    chk("t4_cycles", 64'(cycle_count), 64'd64);
    chk("t4_retires", 64'(retire_count), 64'h0);
    chk("t4_done", 64'(done), 64'h1);

    // 5: halt on the watchdog's last cycle wins, then restart from HALTED
    end_pc = 32'h200;
    do_start();
    n = 0;
    while (cycle_count != 32'd63 && n < 200) begin tick(); n++; end
    chk("t5_wait", 64'(n), 64'd63);
    do_retire(32'h200, 32'h0);
    chk("t5_halted", 64'(state), 64'h2);
    chk("t5_cycles", 64'(cycle_count), 64'd64);
    chk("t5_retires", 64'(retire_count), 64'd1);
    do_start();
    chk("t5_restart", 64'(state), 64'h1);
    chk("t5_clr_cycles", 64'(cycle_count), 64'h0);
    chk("t5_clr_retires", 64'(retire_count), 64'h0);
    rd_req = 1'b1; rd_idx = 4'd0;
    tick();
    rd_req = 1'b0;
    chk("t5_rd_in_run", 64'(rd_valid), 64'h0);

    // 6: instruction word capture; start during RUN is ignored
    end_pc = 32'hFFFF_FFF0;
    do_retire(32'h300, 32'h1111_2222);
    do_start();
    chk("t6_start_ignored", 64'(retire_count), 64'd1);
    end_pc = 32'h0;
    do_retire(32'h0, 32'h2008_000C);
    chk("t6_halted", 64'(state), 64'h2);
    rd(0, rd_exp_t'{1'b0, 32'h300, ei(32'h1111_2222)});
    rd(1, rd_exp_t'{1'b0, 32'h0, ei(32'h2008_000C)});
    rd(2, rd_exp_t'{1'b1, 32'h0, 32'h0});

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
    chk("rd_drain", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
